// File: rtl/load_store_unit_pkg.sv
// Shared codes for the load/store unit: funct3 size codes, trap causes, FSM states.
// Also holds the funct3 -> access size decode used by the top and the load aligner.
package load_store_unit_pkg;

   localparam logic TRUE  = 1'b1;
   localparam logic FALSE = 1'b0;

   localparam logic [2:0] F3_B  = 3'd0;
   localparam logic [2:0] F3_H  = 3'd1;
   localparam logic [2:0] F3_W  = 3'd2;
   localparam logic [2:0] F3_BU = 3'd4;
   localparam logic [2:0] F3_HU = 3'd5;

   localparam logic [31:0] MCAUSE_LOAD_MISALIGN  = 32'd4;
   localparam logic [31:0] MCAUSE_STORE_MISALIGN = 32'd6;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      RESP = 2'd3
   } lsu_state_e;

   typedef enum logic [1:0] {
      SZ_B = 2'd0,
      SZ_H = 2'd1,
      SZ_W = 2'd2
   } size_e;

   // Undefined codes 3, 6 and 7 fall through to a full word.
   function automatic size_e f3_size(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return SZ_B;
         2'd1:    return SZ_H;
         default: return SZ_W;
      endcase
   endfunction

endpackage

// File: rtl/load_store_unit_load_align.sv
// Load data aligner: selects the addressed byte/half lane and sign- or zero-extends.
// Purely combinational.
module load_align
   import load_store_unit_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  offset,
   input  logic [2:0]  funct3,
   output logic [31:0] data
);

   logic [31:0] shifted;

   always_comb begin
      shifted = rdata >> {offset, 3'b000};
      case (f3_size(funct3))
         SZ_B:    data = (funct3 == F3_BU) ? {24'h0, shifted[7:0]}
                                           : {{24{shifted[7]}}, shifted[7:0]};
         SZ_H:    data = (funct3 == F3_HU) ? {16'h0, shifted[15:0]}
                                           : {{16{shifted[15]}}, shifted[15:0]};
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one access in flight, word-aligned RAM port with byte strobes.
// Load writeback three cycles after accept at best; req_ready only in IDLE, mem_req held until mem_gnt.
// Define LSU_MISALIGN_EXC_EN to trap misaligned accesses; otherwise they are aligned down.
module load_store_unit
   import load_store_unit_pkg::*;
#(
   parameter int unsigned DMEM_SIZE = 4096
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [4:0]  req_rd,
   output logic        rsp_valid,
   output logic [4:0]  rsp_rd,
   output logic [31:0] rsp_data,
   output logic        busy,
   output logic        exc_valid,
   output logic [31:0] exc_mcause,
   output logic [31:0] exc_tval,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [3:0]  mem_wstrb,
   output logic [31:0] mem_wdata,
   input  logic        mem_gnt,
   input  logic        mem_rvalid,
   input  logic [31:0] mem_rdata
);

   localparam logic [31:0] ADDR_MASK = 32'(DMEM_SIZE - 1);

   lsu_state_e  state_q, state_d;
   logic        write_q, write_d;
   logic [2:0]  f3_q, f3_d;
   logic [1:0]  off_q, off_d;
   logic [4:0]  rd_q, rd_d;
   logic        rsp_valid_q, rsp_valid_d;
   logic [4:0]  rsp_rd_q, rsp_rd_d;
   logic [31:0] rsp_data_q, rsp_data_d;
   logic        exc_valid_q, exc_valid_d;
   logic [31:0] exc_mcause_q, exc_mcause_d;
   logic [31:0] exc_tval_q, exc_tval_d;
   logic        mem_req_q, mem_req_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_addr_q, mem_addr_d;
   logic [3:0]  mem_wstrb_q, mem_wstrb_d;
   logic [31:0] mem_wdata_q, mem_wdata_d;

   size_e       req_size;
   logic        misaligned;
   logic [31:0] acc_addr;
   logic [31:0] load_data;

   assign req_size = f3_size(req_funct3);

`ifdef LSU_MISALIGN_EXC_EN
   always_comb begin
      misaligned = FALSE;
      case (req_size)
         SZ_H:    misaligned = req_addr[0];
         SZ_W:    misaligned = |req_addr[1:0];
         default: misaligned = FALSE;
      endcase
   end
   assign acc_addr = req_addr;
`else
   assign misaligned = FALSE;
   always_comb begin
      acc_addr = req_addr;
      case (req_size)
         SZ_H:    acc_addr[0]   = 1'b0;
         SZ_W:    acc_addr[1:0] = 2'b00;
         default: acc_addr      = req_addr;
      endcase
   end
`endif

   load_align u_load_align (
      .rdata  (mem_rdata),
      .offset (off_q),
      .funct3 (f3_q),
      .data   (load_data)
   );

   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      f3_d         = f3_q;
      off_d        = off_q;
      rd_d         = rd_q;
      rsp_valid_d  = FALSE;
      rsp_rd_d     = '0;
      rsp_data_d   = '0;
      exc_valid_d  = FALSE;
      exc_mcause_d = '0;
      exc_tval_d   = '0;
      mem_req_d    = mem_req_q;
      mem_we_d     = mem_we_q;
      mem_addr_d   = mem_addr_q;
      mem_wstrb_d  = mem_wstrb_q;
      mem_wdata_d  = mem_wdata_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               write_d = req_write;
               f3_d    = req_funct3;
               off_d   = acc_addr[1:0];
               rd_d    = req_rd;
               if (misaligned) begin
                  // Trap is reported from RESP so it lands one cycle after accept.
                  state_d      = RESP;
                  exc_valid_d  = TRUE;
                  exc_mcause_d = req_write ? MCAUSE_STORE_MISALIGN : MCAUSE_LOAD_MISALIGN;
                  exc_tval_d   = req_addr;
               end else begin
                  state_d     = REQ;
                  mem_req_d   = TRUE;
                  mem_we_d    = req_write;
                  mem_addr_d  = {acc_addr[31:2], 2'b00} & ADDR_MASK;
                  mem_wstrb_d = 4'h0;
                  mem_wdata_d = '0;
                  if (req_write) begin
                     case (req_size)
                        SZ_B: begin
                           mem_wstrb_d = 4'b0001 << acc_addr[1:0];
                           mem_wdata_d = {4{req_wdata[7:0]}};
                        end
                        SZ_H: begin
                           mem_wstrb_d = 4'b0011 << acc_addr[1:0];
                           mem_wdata_d = {2{req_wdata[15:0]}};
                        end
                        default: begin
                           mem_wstrb_d = 4'b1111;
                           mem_wdata_d = req_wdata;
                        end
                     endcase
                  end
               end
            end
         end
         REQ: begin
            if (mem_gnt) begin
               state_d     = write_q ? IDLE : WAIT;
               mem_req_d   = FALSE;
               mem_we_d    = FALSE;
               mem_addr_d  = '0;
               mem_wstrb_d = '0;
               mem_wdata_d = '0;
            end
         end
         WAIT: begin
            if (mem_rvalid) begin
               state_d     = RESP;
               rsp_valid_d = TRUE;
               rsp_rd_d    = rd_q;
               rsp_data_d  = load_data;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q      <= IDLE;
         write_q      <= FALSE;
         f3_q         <= '0;
         off_q        <= '0;
         rd_q         <= '0;
         rsp_valid_q  <= FALSE;
         rsp_rd_q     <= '0;
         rsp_data_q   <= '0;
         exc_valid_q  <= FALSE;
         exc_mcause_q <= '0;
         exc_tval_q   <= '0;
         mem_req_q    <= FALSE;
         mem_we_q     <= FALSE;
         mem_addr_q   <= '0;
         mem_wstrb_q  <= '0;
         mem_wdata_q  <= '0;
      end else begin
         state_q      <= state_d;
         write_q      <= write_d;
         f3_q         <= f3_d;
         off_q        <= off_d;
         rd_q         <= rd_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rd_q     <= rsp_rd_d;
         rsp_data_q   <= rsp_data_d;
         exc_valid_q  <= exc_valid_d;
         exc_mcause_q <= exc_mcause_d;
         exc_tval_q   <= exc_tval_d;
         mem_req_q    <= mem_req_d;
         mem_we_q     <= mem_we_d;
         mem_addr_q   <= mem_addr_d;
         mem_wstrb_q  <= mem_wstrb_d;
         mem_wdata_q  <= mem_wdata_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign busy       = (state_q != IDLE) || (req_valid && state_q == IDLE);
   assign rsp_valid  = rsp_valid_q;
   assign rsp_rd     = rsp_rd_q;
   assign rsp_data   = rsp_data_q;
   assign exc_valid  = exc_valid_q;
   assign exc_mcause = exc_mcause_q;
   assign exc_tval   = exc_tval_q;
   assign mem_req    = mem_req_q;
   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wstrb  = mem_wstrb_q;
   assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed reference memory, RAM responder, scoreboard monitor.
module tb_load_store_unit;

   localparam int DMEM = 4096;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
   } mem_exp_t;
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } rsp_exp_t;
   typedef struct {
      logic [31:0] cause;
      logic [31:0] tval;
   } exc_exp_t;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        req_valid = 1'b0, req_write = 1'b0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [4:0]  req_rd = '0;
   logic        req_ready, rsp_valid, busy, exc_valid;
   logic [4:0]  rsp_rd;
   logic [31:0] rsp_data, exc_mcause, exc_tval;
   logic        mem_req, mem_we;
   logic [31:0] mem_addr, mem_wdata;
   logic [3:0]  mem_wstrb;
   logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
   logic [31:0] mem_rdata = '0;

   int checks = 0;
   int failures = 0;

   mem_exp_t exp_mem_q[$];
   rsp_exp_t exp_rsp_q[$];
   exc_exp_t exp_exc_q[$];

   logic [7:0]  ref_mem [DMEM];
   logic [31:0] ram [DMEM/4];
   int          store_f3 [6] = '{0, 1, 2, 3, 6, 7};

   int gnt_delay_cfg = 0;
   int rv_delay_cfg  = 0;
   bit ram_auto      = 1'b1;
   bit spurious_en   = 1'b0;

   load_store_unit #(.DMEM_SIZE(DMEM)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
      .rsp_valid(rsp_valid), .rsp_rd(rsp_rd), .rsp_data(rsp_data), .busy(busy),
      .exc_valid(exc_valid), .exc_mcause(exc_mcause), .exc_tval(exc_tval),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
      .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%08h required=%08h", name, act, req);
      end
   endtask

   // Reference model: byte-addressed memory and the RV32I access rules.
   function automatic void model(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [4:0] rd);
      int          size, idx, lane;
      logic [31:0] ea, val;
      mem_exp_t    me;
      rsp_exp_t    re;
      exc_exp_t    xe;
      size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
`ifdef LSU_MISALIGN_EXC_EN
      if (a % size != 0) begin
         xe.cause = wr ? 32'd6 : 32'd4;
         xe.tval  = a;
         exp_exc_q.push_back(xe);
         return;
      end
`endif
      ea   = a - (a % size);
      idx  = int'(ea % DMEM);
      lane = idx % 4;
      me.we   = wr;
      me.addr = 32'(idx - lane);
      me.strb = '0;
      me.wdata = '0;
      if (wr) begin
         me.strb  = 4'(((1 << size) - 1) << lane);
         me.wdata = (size == 1) ? (wd & 32'hFF) * 32'h01010101 :
                    (size == 2) ? (wd & 32'hFFFF) * 32'h00010001 : wd;
         for (int i = 0; i < size; i++) ref_mem[idx + i] = wd[8*i +: 8];
      end else begin
         val = '0;
         for (int i = 0; i < size; i++) val = val | (32'(ref_mem[idx + i]) << (8 * i));
         if (f3 == 3'd0 && val[7])  val = val | 32'hFFFFFF00;
         if (f3 == 3'd1 && val[15]) val = val | 32'hFFFF0000;
         re.rd   = rd;
         re.data = val;
         exp_rsp_q.push_back(re);
      end
      exp_mem_q.push_back(me);
   endfunction

   task automatic poke(input int a, input logic [31:0] v);
      ram[a / 4] = v;
      for (int i = 0; i < 4; i++) ref_mem[a + i] = v[8*i +: 8];
   endtask

   // Presents a request (possibly while busy) and returns #1 after the accepting edge.
   task automatic issue(input logic wr, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd);
      int n = 0;
      @(negedge clock);
      req_valid = 1'b1; req_write = wr; req_funct3 = f3;
      req_addr = a; req_wdata = wd; req_rd = rd;
      #1;
      chk("busy_with_valid", {31'b0, busy}, 32'd1);
      while (!req_ready && n < 60) begin
         @(negedge clock); #1; n++;
      end
      if (!req_ready) begin
         chk("accept_timeout", {31'b0, req_ready}, 32'd1);
         req_valid = 1'b0;
         return;
      end
      @(posedge clock); #1;
      req_valid = 1'b0;
      model(wr, f3, a, wd, rd);
   endtask

   task automatic wait_rsp(input string name, input logic [31:0] data, input int lat);
      int n = 1;  // the accepting edge
      while (!rsp_valid && n < 20) begin
         @(posedge clock); #1; n++;
      end
      chk({name, "_valid"}, {31'b0, rsp_valid}, 32'd1);
      chk({name, "_data"}, rsp_data, data);
      if (lat > 0) chk({name, "_latency"}, n, lat);
   endtask

   // RAM responder.
   initial begin : responder
      bit          in_req = 0, rv_pending = 0;
      int          gnt_cnt = 0, rv_cnt = 0, idx = 0;
      forever begin
         @(negedge clock);
         if (!ram_auto) continue;
         mem_gnt = 1'b0; mem_rvalid = 1'b0;
         if (!reset) begin
            in_req = 0; rv_pending = 0;
         end else if (rv_pending) begin
            if (rv_cnt == 0) begin
               mem_rvalid = 1'b1; mem_rdata = ram[idx]; rv_pending = 0;
            end else rv_cnt--;
         end else if (mem_req) begin
            if (!in_req) begin
               in_req = 1;
               gnt_cnt = (gnt_delay_cfg < 0) ? int'($urandom_range(0, 3)) : gnt_delay_cfg;
            end
            if (gnt_cnt == 0) begin
               mem_gnt = 1'b1; in_req = 0;
               idx = int'(mem_addr % DMEM) / 4;
               if (mem_we) begin
                  for (int b = 0; b < 4; b++)
                     if (mem_wstrb[b]) ram[idx][8*b +: 8] = mem_wdata[8*b +: 8];
               end else begin
                  rv_pending = 1;
                  rv_cnt = (rv_delay_cfg < 0) ? int'($urandom_range(0, 3)) : rv_delay_cfg;
               end
            end else gnt_cnt--;
         end else if (spurious_en) begin
            mem_gnt    = ($urandom_range(0, 7) == 0);
            mem_rvalid = ($urandom_range(0, 7) == 0);
            mem_rdata  = $urandom;
         end
      end
   end

   // Scoreboard monitor.
   initial begin : monitor
      bit          seen = 0;
      logic [68:0] snap = '0;
      mem_exp_t    me;
      rsp_exp_t    re;
      exc_exp_t    xe;
      forever begin
         @(negedge clock);
         if (!reset) begin
            seen = 0;
            continue;
         end
         if (mem_req) begin
            if (!seen) begin
               seen = 1;
               snap = {mem_we, mem_addr, mem_wstrb, mem_wdata};
               if (exp_mem_q.size() == 0) chk("mem_req_unexpected", {31'b0, mem_req}, 32'd0);
               else begin
                  me = exp_mem_q.pop_front();
                  chk("mem_we", {31'b0, mem_we}, {31'b0, me.we});
                  chk("mem_addr", mem_addr, me.addr);
                  if (me.we) begin
                     chk("mem_wstrb", {28'b0, mem_wstrb}, {28'b0, me.strb});
                     chk("mem_wdata", mem_wdata, me.wdata);
                  end
               end
            end else begin
               chk("mem_stable", {31'b0, ({mem_we, mem_addr, mem_wstrb, mem_wdata} !== snap)}, 32'd0);
            end
         end else seen = 0;
         if (rsp_valid) begin
            if (exp_rsp_q.size() == 0) chk("rsp_unexpected", {31'b0, rsp_valid}, 32'd0);
            else begin
               re = exp_rsp_q.pop_front();
               chk("rsp_rd", {27'b0, rsp_rd}, {27'b0, re.rd});
               chk("rsp_data", rsp_data, re.data);
            end
         end
         if (exc_valid) begin
            if (exp_exc_q.size() == 0) chk("exc_unexpected", {31'b0, exc_valid}, 32'd0);
            else begin
               xe = exp_exc_q.pop_front();
               chk("exc_mcause", exc_mcause, xe.cause);
               chk("exc_tval", exc_tval, xe.tval);
            end
         end
      end
   end

   initial begin : stim
      logic        wr;
      logic [2:0]  f3;
      logic [31:0] a;
      int          n;
      for (int i = 0; i < DMEM / 4; i++) poke(i * 4, $urandom);

      // Reset state
      #12;
      chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_exc_valid", {31'b0, exc_valid}, 32'd0);
      chk("rst_mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
      @(negedge clock); reset = 1'b1;

      // SW 0xDEADBEEF @0x10, grant on the first request cycle
      issue(1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 5'd0);
      chk("sw_mem_addr", mem_addr, 32'h10);
      chk("sw_mem_wstrb", {28'b0, mem_wstrb}, 32'hF);
      chk("sw_not_ready", {31'b0, req_ready}, 32'd0);
      @(posedge clock); #1;
      chk("sw_idle_after_2", {31'b0, req_ready}, 32'd1);

      // LB / LBU @0x13
      poke(32'h10, 32'h80112233);
      issue(1'b0, 3'd0, 32'h13, 32'h0, 5'd5);
      wait_rsp("lb", 32'hFFFFFF80, 3);
      issue(1'b0, 3'd4, 32'h13, 32'h0, 5'd6);
      wait_rsp("lbu", 32'h00000080, 3);

      // SH 0x1234ABCD @0x22
      issue(1'b1, 3'd1, 32'h22, 32'h1234ABCD, 5'd0);
      chk("sh_mem_wstrb", {28'b0, mem_wstrb}, 32'hC);
      chk("sh_mem_wdata", mem_wdata, 32'hABCDABCD);

      // LW @0x6
      poke(32'h4, 32'hCAFEF00D);
      issue(1'b0, 3'd2, 32'h6, 32'h0, 5'd9);
`ifdef LSU_MISALIGN_EXC_EN
      chk("lw6_no_mem_req", {31'b0, mem_req}, 32'd0);
      @(posedge clock); #1;
      chk("lw6_exc_valid", {31'b0, exc_valid}, 32'd1);
      chk("lw6_mcause", exc_mcause, 32'd4);
      chk("lw6_tval", exc_tval, 32'h6);
`else
      chk("lw6_mem_addr", mem_addr, 32'h4);
      wait_rsp("lw6", 32'hCAFEF00D, 3);
`endif

      // Grant delayed 5 cycles
      gnt_delay_cfg = 5;
      issue(1'b0, 3'd1, 32'h22, 32'h0, 5'd3);
      for (int k = 0; k < 6; k++) begin
         chk("gnt_wait_mem_req", {31'b0, mem_req}, 32'd1);
         chk("gnt_wait_busy", {31'b0, busy}, 32'd1);
         @(posedge clock); #1;
      end
      chk("gnt_done_mem_req", {31'b0, mem_req}, 32'd0);
      wait_rsp("gnt_delay", 32'hFFFFABCD, 0);
      gnt_delay_cfg = 0;

      // Randomized traffic with random RAM latencies and stray gnt/rvalid pulses
      gnt_delay_cfg = -1; rv_delay_cfg = -1; spurious_en = 1'b1;
      for (int t = 0; t < 300; t++) begin
         wr = 1'($urandom_range(0, 1));
         f3 = wr ? 3'(store_f3[$urandom_range(0, 5)]) : 3'($urandom_range(0, 7));
         a  = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 255));
         issue(wr, f3, a, $urandom, 5'($urandom_range(0, 31)));
         repeat ($urandom_range(0, 2)) @(negedge clock);
      end
      n = 0;
      while ((exp_mem_q.size() + exp_rsp_q.size() + exp_exc_q.size()) != 0 && n < 500) begin
         @(negedge clock); n++;
      end
      chk("drain_pending", 32'(exp_mem_q.size() + exp_rsp_q.size() + exp_exc_q.size()), 32'd0);
      spurious_en = 1'b0; gnt_delay_cfg = 0; rv_delay_cfg = 0;
      repeat (10) @(negedge clock);

      // Reset while waiting for read data
      @(posedge clock); #2;
      ram_auto = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      issue(1'b0, 3'd2, 32'h40, 32'h0, 5'd7);
      chk("rw_mem_req", {31'b0, mem_req}, 32'd1);
      mem_gnt = 1'b1;
      @(posedge clock); #1;
      mem_gnt = 1'b0;
      chk("rw_wait_busy", {31'b0, busy}, 32'd1);
      chk("rw_wait_no_req", {31'b0, mem_req}, 32'd0);
      #1 reset = 1'b0;
      #1;
      chk("rw_rst_ready", {31'b0, req_ready}, 32'd1);
      chk("rw_rst_busy", {31'b0, busy}, 32'd0);
      chk("rw_rst_rsp", {31'b0, rsp_valid}, 32'd0);
      exp_mem_q.delete(); exp_rsp_q.delete(); exp_exc_q.delete();
      @(negedge clock); reset = 1'b1;
      @(posedge clock); #1;
      mem_rvalid = 1'b1; mem_rdata = 32'h12345678;
      @(posedge clock); #1;
      mem_rvalid = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk("rw_no_rsp", {31'b0, rsp_valid}, 32'd0);
         chk("rw_idle", {31'b0, req_ready}, 32'd1);
         @(posedge clock); #1;
      end
      ram_auto = 1'b1;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter DMEM_SIZE, default 4096, data memory size in bytes (power of two).
REQ-002 SHALL have port clock  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req_valid  input  1  MEM stage presents an access.
REQ-005 SHALL have port req_ready  output  1  unit accepts an access this cycle.
REQ-006 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 SHALL have port req_funct3  input  3  RV32I size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-010 SHALL have port req_rd  input  5  load destination register.
REQ-011 SHALL have port rsp_valid / rsp_rd / rsp_data  output  1/5/32  one-cycle load writeback pulse.
REQ-012 SHALL have port busy  output  1  pipeline stall request.
REQ-013 SHALL have port exc_valid / exc_mcause / exc_tval  output  1/32/32  misaligned-access trap.
REQ-014 SHALL have port mem_req / mem_we / mem_addr / mem_wstrb / mem_wdata  output  1/1/32/4/32  word-aligned RAM request.
REQ-015 SHALL have port mem_gnt / mem_rvalid / mem_rdata  input  1/1/32  RAM grant, read-data valid, read data.

Function
REQ-016 SHALL implement FSM states IDLE, REQ, WAIT, RESP.
REQ-017 SHALL assert req_ready only in IDLE; access accepted when req_valid && req_ready, latching all req_* fields.
REQ-018 SHALL move IDLE->REQ on accept; REQ holds mem_req=1 with stable outputs until mem_gnt.
REQ-019 SHALL, on mem_gnt in REQ: store -> IDLE; load -> WAIT.
REQ-020 SHALL, in WAIT, on mem_rvalid capture mem_rdata and go to RESP; RESP drives rsp_valid=1 for exactly one cycle then returns to IDLE.
REQ-021 SHALL drive mem_addr = {addr[31:2],2'b00} masked to DMEM_SIZE-1; out-of-range bits wrap modulo DMEM_SIZE.
REQ-022 SHALL generate mem_wstrb: SB 0001<<addr[1:0], SH 0011<<addr[1:0], SW 1111; mem_wdata replicates byte/half across lanes.
REQ-023 SHALL extract load data by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unmodified.
REQ-024 SHALL treat undefined funct3 (3, 6, 7) as LW/SW.
REQ-025 SHALL assert busy = (state != IDLE) || (req_valid && state==IDLE); minimum latency accept->rsp_valid = 3 cycles with mem_gnt and mem_rvalid each one cycle after request.
REQ-026 SHALL ignore mem_rvalid outside WAIT and mem_gnt outside REQ.
REQ-027 SHALL ignore req_valid while not IDLE; the upstream holds its request under busy.

Reset
REQ-028 SHALL, on reset low, immediately force state IDLE and all outputs 0 except req_ready=1, regardless of in-flight access.
REQ-029 SHALL discard a load interrupted by reset; no rsp_valid follows reset release.

Configuration
REQ-030 SHALL honour macro LSU_MISALIGN_EXC_EN.
REQ-031 SHALL, with LSU_MISALIGN_EXC_EN defined, on accepting a halfword access with addr[0]=1 or word with addr[1:0]!=0: issue no mem_req, pulse exc_valid one cycle later with exc_mcause=4 (load) or 6 (store), exc_tval=addr, return to IDLE.
REQ-032 SHALL, without LSU_MISALIGN_EXC_EN, tie exc_* to 0 and force misaligned addresses down to natural alignment.

Structure
REQ-033 SHALL take funct3 size codes, mcause codes 4/6, FSM state encodings and TRUE/FALSE from the shared defines header.
REQ-034 SHALL place lane extraction and sign extension in combinational sub-module load_align.

Verification
REQ-035 SHALL cover: SW 0xDEADBEEF @0x10, gnt next cycle -> mem_wstrb=1111, mem_addr=0x10, IDLE after 2 cycles.
REQ-036 SHALL cover: LB @0x13, rdata 0x80112233 -> rsp_data=0xFFFFFF80; LBU -> 0x00000080.
REQ-037 SHALL cover: SH 0x1234ABCD @0x22 -> mem_wstrb=1100, mem_wdata=0xABCDABCD.
REQ-038 SHALL cover: LW @0x6 with macro -> exc_valid, mcause=4, tval=0x6, no mem_req; without macro -> mem_addr=0x4, rsp_valid.
REQ-039 SHALL cover: gnt delayed 5 cycles -> mem_req and busy held, outputs stable, single rsp_valid.
REQ-040 SHALL cover: reset asserted in WAIT -> IDLE, req_ready=1, later mem_rvalid produces no rsp_valid.
